// File: rtl/box_frame_rx.sv
// box_frame_rx: parses box-overlay UDP payloads into a working bank and publishes them to the active box bank.
// Define BOX_FRAME_SYNC_EN to hold a received bank as pending until the next frame_sync; by default it goes live right after rx_end.
module box_frame_rx #(
  parameter int          BOX_NUM = 1,
  parameter int          H_ACT   = 1280,
  parameter int          V_ACT   = 720,
  parameter logic [15:0] MAGIC   = 16'hA55A
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_valid,
  input  logic [7:0]                       rx_data,
  input  logic [15:0]                      rx_len,
  input  logic                             rx_end,
  input  logic                             frame_sync,
  output logic [BOX_NUM*$clog2(H_ACT)-1:0] start_xs,
  output logic [BOX_NUM*$clog2(H_ACT)-1:0] end_xs,
  output logic [BOX_NUM*$clog2(V_ACT)-1:0] start_ys,
  output logic [BOX_NUM*$clog2(V_ACT)-1:0] end_ys,
  output logic [BOX_NUM*24-1:0]            colors,
  output logic [BOX_NUM-1:0]               box_valid,
  output logic                             update,
  output logic                             err,
  output logic [2:0]                       err_code,
  output logic [7:0]                       drop_cnt
);
  localparam int          XW   = $clog2(H_ACT);
  localparam int          YW   = $clog2(V_ACT);
  localparam logic [15:0] HMAX = 16'(H_ACT);
  localparam logic [15:0] VMAX = 16'(V_ACT);
  localparam logic [7:0]  NMAX = 8'(BOX_NUM);

  typedef enum logic [2:0] {IDLE, HDR, BODY, CSUM, DRAIN} state_t;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [23:0]   rgb;
  } box_t;

  state_t state_q, state_d;
  logic        hidx_q;
  logic [7:0]  n_q, rec_q, xor_q;
  logic [3:0]  rb_q;
  logic [79:0] tmp_q;
  logic        csum_q, pend_err_q;
  logic        update_q, err_q;
  logic [2:0]  code_q;
  logic [7:0]  drop_q;
  box_t [BOX_NUM-1:0] work_q, act_q;
  logic [BOX_NUM-1:0] act_valid_q;

  logic [7:0]  xor_n;
  logic [15:0] rx0, ry0, rx1, ry1;
  logic        range_bad, berr, lerr, fire, pass, wr_rec, set_pend;
  logic [2:0]  bcode, fcode;
  state_t      nxt;
  box_t        rec_box;
  logic [BOX_NUM-1:0] valid_mask;

  always_comb begin
    state_d   = state_q;
    nxt       = state_q;
    berr      = 1'b0;
    bcode     = '0;
    lerr      = 1'b0;
    fire      = 1'b0;
    fcode     = '0;
    pass      = 1'b0;
    wr_rec    = 1'b0;
    set_pend  = 1'b0;
    xor_n     = xor_q ^ (rx_valid ? rx_data : 8'h00);
    {rx0, ry0, rx1, ry1} = tmp_q[79:16];
    range_bad = (rx0 >= HMAX) || (rx1 >= HMAX) || (ry0 >= VMAX) || (ry1 >= VMAX) ||
                (rx0 > rx1) || (ry0 > ry1);
    rec_box.x0  = rx0[XW-1:0];
    rec_box.x1  = rx1[XW-1:0];
    rec_box.y0  = ry0[YW-1:0];
    rec_box.y1  = ry1[YW-1:0];
    rec_box.rgb = {tmp_q[15:0], rx_data};
    for (int unsigned i = 0; i < BOX_NUM; i++) valid_mask[i] = (8'(i) < n_q);

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          nxt = HDR;
          if (rx_data != MAGIC[15:8]) begin berr = 1'b1; bcode = 3'd1; end
        end
        HDR: begin
          if (!hidx_q) begin
            if (rx_data != MAGIC[7:0]) begin berr = 1'b1; bcode = 3'd1; end
          end else begin
            nxt = BODY;
            if (rx_data == 8'd0 || rx_data > NMAX) begin berr = 1'b1; bcode = 3'd2; end
            else if (rx_len != 16'd4 + 16'd11 * {8'd0, rx_data}) lerr = 1'b1;
          end
        end
        BODY: begin
          if (rb_q == 4'd10) begin
            if (range_bad) begin berr = 1'b1; bcode = 3'd3; end
            else wr_rec = 1'b1;
            if (rec_q == n_q - 8'd1) nxt = CSUM;
          end
        end
        CSUM: if (csum_q) lerr = 1'b1;
        default: ;
      endcase
    end

    // Codes 1-3 report immediately; a length fault seen mid-packet is held in DRAIN and reported at rx_end.
    if (state_q == DRAIN) begin
      if (rx_end) begin
        state_d = IDLE;
        fire    = pend_err_q;
        fcode   = 3'd4;
      end
    end else if (state_q != IDLE || rx_valid) begin
      if (berr) begin
        fire    = 1'b1;
        fcode   = bcode;
        state_d = rx_end ? IDLE : DRAIN;
      end else if (lerr) begin
        if (rx_end) begin
          fire = 1'b1; fcode = 3'd4; state_d = IDLE;
        end else begin
          set_pend = 1'b1; state_d = DRAIN;
        end
      end else if (rx_end) begin
        state_d = IDLE;
        if (state_q == CSUM && (csum_q || rx_valid)) begin
          if (xor_n == 8'h00) pass = 1'b1;
          else begin fire = 1'b1; fcode = 3'd5; end
        end else begin
          fire = 1'b1; fcode = 3'd4;
        end
      end else begin
        state_d = nxt;
      end
    end
  end

`ifdef BOX_FRAME_SYNC_EN
  box_t [BOX_NUM-1:0] pbank_q;
  logic [BOX_NUM-1:0] pvalid_q;
  logic               pend_q;
  logic               commit;
  assign commit = frame_sync && pend_q && !pass;
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hidx_q      <= 1'b0;
      n_q         <= '0;
      rec_q       <= '0;
      rb_q        <= '0;
      tmp_q       <= '0;
      xor_q       <= '0;
      csum_q      <= 1'b0;
      pend_err_q  <= 1'b0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= '0;
      drop_q      <= '0;
      work_q      <= '0;
      act_q       <= '0;
      act_valid_q <= '0;
`ifdef BOX_FRAME_SYNC_EN
      pbank_q     <= '0;
      pvalid_q    <= '0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= fire;
      if (fire) begin
        code_q <= fcode;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
      if (state_q == IDLE) begin
        xor_q      <= rx_data;
        hidx_q     <= 1'b0;
        rec_q      <= '0;
        rb_q       <= '0;
        csum_q     <= 1'b0;
        pend_err_q <= 1'b0;
      end else if (rx_valid && state_q != DRAIN) begin
        xor_q <= xor_n;
      end
      if (set_pend) pend_err_q <= 1'b1;
      if (rx_valid) begin
        case (state_q)
          HDR: begin
            hidx_q <= 1'b1;
            if (hidx_q) n_q <= rx_data;
          end
          BODY: begin
            if (rb_q == 4'd10) begin
              rb_q  <= '0;
              rec_q <= rec_q + 8'd1;
            end else begin
              rb_q  <= rb_q + 4'd1;
              tmp_q <= {tmp_q[71:0], rx_data};
            end
          end
          CSUM:    csum_q <= 1'b1;
          default: ;
        endcase
      end
      if (wr_rec) begin
        for (int unsigned i = 0; i < BOX_NUM; i++)
          if (rec_q == 8'(i)) work_q[i] <= rec_box;
      end
`ifdef BOX_FRAME_SYNC_EN
      if (pass) begin
        pbank_q  <= work_q;
        pvalid_q <= valid_mask;
        pend_q   <= 1'b1;
      end else if (commit) begin
        act_q       <= pbank_q;
        act_valid_q <= pvalid_q;
        pend_q      <= 1'b0;
      end
      update_q <= commit;
`else
      if (pass) begin
        act_q       <= work_q;
        act_valid_q <= valid_mask;
      end
      update_q <= pass;
`endif
    end
  end

  always_comb begin
    start_xs = '0;
    end_xs   = '0;
    start_ys = '0;
    end_ys   = '0;
    colors   = '0;
    for (int unsigned i = 0; i < BOX_NUM; i++) begin
      start_xs[i*XW +: XW] = act_q[i].x0;
      end_xs[i*XW +: XW]   = act_q[i].x1;
      start_ys[i*YW +: YW] = act_q[i].y0;
      end_ys[i*YW +: YW]   = act_q[i].y1;
      colors[i*24 +: 24]   = act_q[i].rgb;
    end
  end

  assign box_valid = act_valid_q;
  assign update    = update_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_box_frame_rx.sv
// Directed bench for box_frame_rx (BOX_NUM=2, 1280x720); expectations follow either commit mode.
`timescale 1ns/1ps
module tb_box_frame_rx;
  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_end, frame_sync;
  logic [7:0]  rx_data;
  logic [15:0] rx_len;
  logic [21:0] start_xs, end_xs;
  logic [19:0] start_ys, end_ys;
  logic [47:0] colors;
  logic [1:0]  box_valid;
  logic        update, err;
  logic [2:0]  err_code;
  logic [7:0]  drop_cnt;

  int passed = 0, total = 0;
  int err_pulses = 0, upd_pulses = 0;
  int err_at, upd_at, err_before;
  logic [7:0] pkt[$];

  box_frame_rx #(.BOX_NUM(2), .H_ACT(1280), .V_ACT(720), .MAGIC(16'hA55A)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_len(rx_len),
    .rx_end(rx_end), .frame_sync(frame_sync),
    .start_xs(start_xs), .end_xs(end_xs), .start_ys(start_ys), .end_ys(end_ys),
    .colors(colors), .box_valid(box_valid), .update(update), .err(err),
    .err_code(err_code), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (update === 1'b1) upd_pulses++;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic hdr(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] n);
    pkt.delete();
    pkt.push_back(m0); pkt.push_back(m1); pkt.push_back(n);
  endtask

  task automatic rec(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] x1,
                     input logic [15:0] y1, input logic [23:0] c);
    pkt.push_back(x0[15:8]); pkt.push_back(x0[7:0]);
    pkt.push_back(y0[15:8]); pkt.push_back(y0[7:0]);
    pkt.push_back(x1[15:8]); pkt.push_back(x1[7:0]);
    pkt.push_back(y1[15:8]); pkt.push_back(y1[7:0]);
    pkt.push_back(c[23:16]); pkt.push_back(c[15:8]); pkt.push_back(c[7:0]);
  endtask

  task automatic csum(input logic [7:0] delta);
    logic [7:0] s;
    s = 8'h00;
    foreach (pkt[i]) s ^= pkt[i];
    pkt.push_back(s + delta);
  endtask

  // Index of the consumed byte (pkt.size() means rx_end) whose edge raised err/update.
  task automatic note(input int idx);
    if (err === 1'b1 && err_at < 0) err_at = idx;
    if (update === 1'b1 && upd_at < 0) upd_at = idx;
  endtask

  task automatic send(input logic [15:0] len, input logic fs);
    err_at = -1;
    upd_at = -1;
    rx_len = len;
    for (int s = 0; s <= pkt.size(); s++) begin
      @(negedge clk);
      if (s > 0) note(s - 1);
      if (s < pkt.size()) begin
        rx_valid = 1'b1; rx_data = pkt[s];
      end else begin
        rx_valid = 1'b0; rx_end = 1'b1; frame_sync = fs;
      end
    end
    @(negedge clk);
    note(pkt.size());
    rx_end = 1'b0; frame_sync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sync_pulse(input logic exp_upd);
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    chk("update_after_sync", update, exp_upd);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_p1(input string tag);
    chk({tag, "_x0"}, start_xs[10:0], 11'd100);
    chk({tag, "_x1"}, end_xs[10:0], 11'd200);
    chk({tag, "_y0"}, start_ys[9:0], 10'd50);
    chk({tag, "_y1"}, end_ys[9:0], 10'd150);
    chk({tag, "_rgb"}, colors[23:0], 24'hFF0000);
    chk({tag, "_valid"}, box_valid, 2'b01);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_len = '0; rx_end = 1'b0; frame_sync = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", box_valid, 2'b00);
    chk("rst_drop", drop_cnt, 8'd0);
    chk("rst_code", err_code, 3'd0);
    chk("rst_update", update, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_xs", start_xs, 22'd0);

    // Good packet, frame_sync coincident with rx_end
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd100, 16'd50, 16'd200, 16'd150, 24'hFF0000); csum(8'd0);
    send(16'd15, 1'b1);
`ifdef BOX_FRAME_SYNC_EN
    chk("p1_not_yet", box_valid, 2'b00);
    chk("p1_no_upd", upd_pulses, 0);
    sync_pulse(1'b1);
    sync_pulse(1'b0);
`else
    chk("p1_upd_at", upd_at, 15);
`endif
    check_p1("p1");
    chk("p1_upd_cnt", upd_pulses, 1);
    chk("p1_drop", drop_cnt, 8'd0);
    chk("p1_errs", err_pulses, 0);

    // Bad magic
    hdr(8'hA5, 8'h5B, 8'd1); rec(16'd1, 16'd2, 16'd3, 16'd4, 24'h0000FF); csum(8'd0);
    send(16'd15, 1'b0);
    chk("magic_at", err_at, 1);
    chk("magic_code", err_code, 3'd1);
    chk("magic_drop", drop_cnt, 8'd1);
    chk("magic_errs", err_pulses, 1);
    check_p1("magic_keep");

    // x1 out of range
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd100, 16'd50, 16'd1280, 16'd150, 24'h00FF00); csum(8'd0);
    send(16'd15, 1'b0);
    chk("range_at", err_at, 13);
    chk("range_code", err_code, 3'd3);
    chk("range_drop", drop_cnt, 8'd2);
    chk("range_errs", err_pulses, 2);

    // Checksum off by one
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd100, 16'd50, 16'd200, 16'd150, 24'h0000FF); csum(8'd1);
    send(16'd15, 1'b0);
    chk("csum_at", err_at, 15);
    chk("csum_code", err_code, 3'd5);
    chk("csum_drop", drop_cnt, 8'd3);

    // Declared length 14 for N=1
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd100, 16'd50, 16'd200, 16'd150, 24'h0000FF); csum(8'd0);
    send(16'd14, 1'b0);
    chk("len_at", err_at, 15);
    chk("len_code", err_code, 3'd4);
    chk("len_drop", drop_cnt, 8'd4);
    check_p1("len_keep");

    // N == 0 and N > BOX_NUM
    hdr(8'hA5, 8'h5A, 8'd0); csum(8'd0);
    send(16'd4, 1'b0);
    chk("n0_at", err_at, 2);
    chk("n0_code", err_code, 3'd2);
    hdr(8'hA5, 8'h5A, 8'd3); csum(8'd0);
    send(16'd37, 1'b0);
    chk("n3_at", err_at, 2);
    chk("n3_drop", drop_cnt, 8'd6);

    // rx_end in the middle of the first record
    hdr(8'hA5, 8'h5A, 8'd1); pkt.push_back(8'h00); pkt.push_back(8'h64);
    send(16'd15, 1'b0);
    chk("short_at", err_at, 5);
    chk("short_code", err_code, 3'd4);
    chk("short_drop", drop_cnt, 8'd7);
    chk("short_errs", err_pulses, 7);

    // Packet A (two boxes at the range limits) then packet B
    hdr(8'hA5, 8'h5A, 8'd2);
    rec(16'd0, 16'd0, 16'd1279, 16'd719, 24'h123456);
    rec(16'd10, 16'd20, 16'd10, 16'd20, 24'hABCDEF);
    csum(8'd0);
    send(16'd26, 1'b0);
`ifdef BOX_FRAME_SYNC_EN
    chk("a_pending", box_valid, 2'b01);
    chk("a_rgb_old", colors[23:0], 24'hFF0000);
`else
    chk("a_valid", box_valid, 2'b11);
    chk("a_xs", start_xs, {11'd10, 11'd0});
    chk("a_xe", end_xs, {11'd10, 11'd1279});
    chk("a_ys", start_ys, {10'd20, 10'd0});
    chk("a_ye", end_ys, {10'd20, 10'd719});
    chk("a_rgb", colors, {24'hABCDEF, 24'h123456});
`endif
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd300, 16'd400, 16'd500, 16'd600, 24'h00FF00); csum(8'd0);
    send(16'd15, 1'b0);
`ifdef BOX_FRAME_SYNC_EN
    sync_pulse(1'b1);
    chk("b_upd_cnt", upd_pulses, 2);
`else
    chk("b_upd_cnt", upd_pulses, 3);
`endif
    chk("b_valid", box_valid, 2'b01);
    chk("b_x0", start_xs[10:0], 11'd300);
    chk("b_x1", end_xs[10:0], 11'd500);
    chk("b_y0", start_ys[9:0], 10'd400);
    chk("b_y1", end_ys[9:0], 10'd600);
    chk("b_rgb", colors[23:0], 24'h00FF00);
    chk("b_drop", drop_cnt, 8'd7);

    // Reset in the middle of BODY, with a byte presented in the reset cycle
    hdr(8'hA5, 8'h5A, 8'd1); rec(16'd100, 16'd50, 16'd200, 16'd150, 24'hFF0000); csum(8'd0);
    rx_len = 16'd15;
    err_before = err_pulses;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = pkt[s];
    end
    @(negedge clk); rst = 1'b1; rx_data = pkt[6];
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", box_valid, 2'b00);
    chk("mrst_xs", start_xs, 22'd0);
    chk("mrst_rgb", colors, 48'd0);
    chk("mrst_drop", drop_cnt, 8'd0);
    chk("mrst_code", err_code, 3'd0);
    chk("mrst_upd", update, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    send(16'd15, 1'b0);
`ifdef BOX_FRAME_SYNC_EN
    sync_pulse(1'b1);
`endif
    check_p1("after_rst");
    chk("after_rst_drop", drop_cnt, 8'd0);
    chk("after_rst_errs", err_pulses, err_before);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
